// File: rtl/dram_arbiter_pkg.sv
// Shared constants and types for the DRAM arbiter.
//   ADDR_W / DATA_W : DRAM port widths
//   state_e         : arbiter FSM state encoding (2 bits)
//   addr_oor()      : true when an address falls outside the populated DRAM
package dram_arbiter_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   // Address is out of range when it is at or beyond the number of valid words.
   function automatic logic addr_oor(input logic [ADDR_W-1:0] addr,
                                     input int unsigned       depth);
      return (32'(addr) >= depth);
   endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// Bundle of the core-side request/ack bus and the DRAM port.
//   core_req/core_we/core_addr/core_wdata : per-core request (packed, 16 bits per core)
//   core_ack/core_rdata/core_err/busy     : arbiter responses
//   mem_we/mem_addr/mem_wdata/mem_rdata   : single-port DRAM connection
// Modports: arb (arbiter side), env (cores + DRAM side).
interface dram_arbiter_if #(
   parameter int unsigned NUM_CORES = 4
);
   logic [NUM_CORES-1:0]                               core_req;
   logic [NUM_CORES-1:0]                               core_we;
   logic [dram_arbiter_pkg::ADDR_W*NUM_CORES-1:0]      core_addr;
   logic [dram_arbiter_pkg::DATA_W*NUM_CORES-1:0]      core_wdata;
   logic [NUM_CORES-1:0]                               core_ack;
   logic [dram_arbiter_pkg::DATA_W-1:0]                core_rdata;
   logic                                               core_err;
   logic                                               busy;
   logic                                               mem_we;
   logic [dram_arbiter_pkg::ADDR_W-1:0]                mem_addr;
   logic [dram_arbiter_pkg::DATA_W-1:0]                mem_wdata;
   logic [dram_arbiter_pkg::DATA_W-1:0]                mem_rdata;

   modport arb (
      input  core_req, core_we, core_addr, core_wdata, mem_rdata,
      output core_ack, core_rdata, core_err, busy, mem_we, mem_addr, mem_wdata
   );

   modport env (
      output core_req, core_we, core_addr, core_wdata, mem_rdata,
      input  core_ack, core_rdata, core_err, busy, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dram_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
//   req     : request vector
//   ptr     : highest-priority index (must be < NUM_CORES)
//   idx_c   : winning index
//   valid_c : at least one request is set
module dram_arbiter_rr_picker #(
   parameter  int unsigned NUM_CORES = 4,
   localparam int unsigned IDX_W     = $clog2(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [IDX_W-1:0]     idx_c,
   output logic                 valid_c
);

   // One extra bit so ptr + offset can exceed NUM_CORES-1 before the wrap.
   logic [IDX_W:0] cand;

   always_comb begin
      idx_c   = '0;
      valid_c = 1'b0;
      cand    = '0;
      for (int i = 0; i < int'(NUM_CORES); i++) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(NUM_CORES)) begin
            cand = cand - (IDX_W+1)'(NUM_CORES);
         end
         if (!valid_c && req[cand[IDX_W-1:0]]) begin
            valid_c = 1'b1;
            idx_c   = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port DRAM between NUM_CORES cores.
// Each transaction runs IDLE -> ISSUE -> WAIT -> RESP -> IDLE (4 cycles).
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : core request/ack bus and DRAM port (arb modport)
module dram_arbiter
   import dram_arbiter_pkg::*;
#(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned MEM_DEPTH = 1025
) (
   input logic            clk,
   input logic            rst,
   dram_arbiter_if.arb    bus
);

   localparam int unsigned IDX_W = $clog2(NUM_CORES);

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      grant_q, grant_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic                  err_q, err_d;
   logic                  op_we_q, op_we_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
   logic [NUM_CORES-1:0]  core_ack_q, core_ack_d;
   logic [DATA_W-1:0]     core_rdata_q, core_rdata_d;
   logic                  core_err_q, core_err_d;
   logic                  busy_q, busy_d;

   logic [IDX_W-1:0]      pick_idx;
   logic                  pick_valid;
   logic                  pick_oor;

   logic [ADDR_W-1:0]     req_addr  [NUM_CORES];
   logic [DATA_W-1:0]     req_wdata [NUM_CORES];

   // Unpack the per-core address/data buses.
   for (genvar c = 0; c < int'(NUM_CORES); c++) begin : g_unpack
      assign req_addr[c]  = bus.core_addr[ADDR_W*c +: ADDR_W];
      assign req_wdata[c] = bus.core_wdata[DATA_W*c +: DATA_W];
   end

   dram_arbiter_rr_picker #(
      .NUM_CORES (NUM_CORES)
   ) u_picker (
      .req     (bus.core_req),
      .ptr     (rr_ptr_q),
      .idx_c   (pick_idx),
      .valid_c (pick_valid)
   );

   // Next-state and output logic.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rr_ptr_d     = rr_ptr_q;
      err_d        = err_q;
      op_we_d      = op_we_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      core_ack_d   = '0;
      core_rdata_d = core_rdata_q;
      core_err_d   = 1'b0;
      pick_oor     = addr_oor(req_addr[pick_idx], MEM_DEPTH);

      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               grant_d     = pick_idx;
               err_d       = pick_oor;
               op_we_d     = bus.core_we[pick_idx];
               // Out-of-range writes are dropped by never raising the strobe.
               mem_we_d    = bus.core_we[pick_idx] & ~pick_oor;
               mem_addr_d  = req_addr[pick_idx];
               mem_wdata_d = req_wdata[pick_idx];
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // DRAM read data is valid this cycle; writes leave rdata untouched.
            if (err_q) begin
               core_rdata_d = '0;
            end else if (!op_we_q) begin
               core_rdata_d = bus.mem_rdata;
            end
            core_ack_d[grant_q] = 1'b1;
            core_err_d          = err_q;
            state_d             = ST_RESP;
         end
         ST_RESP: begin
            rr_ptr_d = (grant_q == IDX_W'(NUM_CORES - 1)) ? '0 : grant_q + IDX_W'(1);
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         rr_ptr_q     <= '0;
         err_q        <= 1'b0;
         op_we_q      <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         core_ack_q   <= '0;
         core_rdata_q <= '0;
         core_err_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         rr_ptr_q     <= rr_ptr_d;
         err_q        <= err_d;
         op_we_q      <= op_we_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         core_ack_q   <= core_ack_d;
         core_rdata_q <= core_rdata_d;
         core_err_q   <= core_err_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.core_ack   = core_ack_q;
   assign bus.core_rdata = core_rdata_q;
   assign bus.core_err   = core_err_q;
   assign bus.busy       = busy_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed self-checking bench for dram_arbiter with a behavioural DRAM model.
module tb_dram_arbiter;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_mis;
   int   we_cnt;

   logic [15:0] ram [65536];

   dram_arbiter_if #(.NUM_CORES(4)) bus ();

   dram_arbiter #(
      .NUM_CORES (4),
      .MEM_DEPTH (1025)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.arb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port DRAM: write-enable plus one-cycle registered read.
   always @(posedge clk) begin
      if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) we_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_core(input int c, input logic req, input logic we,
                           input logic [15:0] addr, input logic [15:0] wdata);
      bus.core_req[c]             = req;
      bus.core_we[c]              = we;
      bus.core_addr[16*c +: 16]   = addr;
      bus.core_wdata[16*c +: 16]  = wdata;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(2);
      n_cmp++; if (bus.core_ack !== 4'b0000) begin n_mis++; $display("FAIL rst_ack: got %b want 0000", bus.core_ack); end
      n_cmp++; if (bus.core_rdata !== 16'h0) begin n_mis++; $display("FAIL rst_rdata: got %h want 0000", bus.core_rdata); end
      n_cmp++; if (bus.core_err !== 1'b0) begin n_mis++; $display("FAIL rst_err: got %b want 0", bus.core_err); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.mem_we !== 1'b0) begin n_mis++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
      n_cmp++; if (bus.mem_addr !== 16'h0) begin n_mis++; $display("FAIL rst_mem_addr: got %h want 0000", bus.mem_addr); end
      n_cmp++; if (bus.mem_wdata !== 16'h0) begin n_mis++; $display("FAIL rst_mem_wdata: got %h want 0000", bus.mem_wdata); end
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      we_cnt = 0;
      set_core(1, 1'b1, 1'b0, 16'd5, 16'h0);
      tick(1);
      n_cmp++; if (bus.busy !== 1'b1) begin n_mis++; $display("FAIL rd_busy_issue: got %b want 1", bus.busy); end
      n_cmp++; if (bus.mem_addr !== 16'd5) begin n_mis++; $display("FAIL rd_mem_addr: got %0d want 5", bus.mem_addr); end
      tick(1);
      n_cmp++; if (bus.core_ack !== 4'b0000) begin n_mis++; $display("FAIL rd_early_ack: got %b want 0000", bus.core_ack); end
      tick(1);
      n_cmp++; if (bus.core_ack !== 4'b0010) begin n_mis++; $display("FAIL rd_ack: got %b want 0010", bus.core_ack); end
      n_cmp++; if (bus.core_rdata !== 16'd22) begin n_mis++; $display("FAIL rd_rdata: got %0d want 22", bus.core_rdata); end
      n_cmp++; if (bus.core_err !== 1'b0) begin n_mis++; $display("FAIL rd_err: got %b want 0", bus.core_err); end
      set_core(1, 1'b0, 1'b0, 16'd5, 16'h0);
      tick(1);
      n_cmp++; if (bus.core_ack !== 4'b0000) begin n_mis++; $display("FAIL rd_ack_pulse: got %b want 0000", bus.core_ack); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL rd_busy_idle: got %b want 0", bus.busy); end
      n_cmp++; if (we_cnt !== 0) begin n_mis++; $display("FAIL rd_no_we: got %0d want 0", we_cnt); end
   endtask

   task automatic test_write_read();
      we_cnt = 0;
      set_core(2, 1'b1, 1'b1, 16'd100, 16'hBEEF);
      tick(1);
      n_cmp++; if (bus.mem_we !== 1'b1) begin n_mis++; $display("FAIL wr_mem_we: got %b want 1", bus.mem_we); end
      n_cmp++; if (bus.mem_wdata !== 16'hBEEF) begin n_mis++; $display("FAIL wr_mem_wdata: got %h want beef", bus.mem_wdata); end
      tick(1);
      n_cmp++; if (bus.mem_we !== 1'b0) begin n_mis++; $display("FAIL wr_we_drop: got %b want 0", bus.mem_we); end
      tick(1);
      n_cmp++; if (bus.core_ack !== 4'b0100) begin n_mis++; $display("FAIL wr_ack: got %b want 0100", bus.core_ack); end
      n_cmp++; if (bus.core_rdata !== 16'd22) begin n_mis++; $display("FAIL wr_rdata_hold: got %0d want 22", bus.core_rdata); end
      // Keep req high and switch to a read: becomes the next transaction.
      set_core(2, 1'b1, 1'b0, 16'd100, 16'h0);
      tick(1);
      n_cmp++; if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL wr_idle_gap: got %b want 0", bus.busy); end
      tick(3);
      n_cmp++; if (bus.core_ack !== 4'b0100) begin n_mis++; $display("FAIL wr_rd_ack: got %b want 0100", bus.core_ack); end
      n_cmp++; if (bus.core_rdata !== 16'hBEEF) begin n_mis++; $display("FAIL wr_rd_rdata: got %h want beef", bus.core_rdata); end
      set_core(2, 1'b0, 1'b0, 16'd100, 16'h0);
      tick(1);
      n_cmp++; if (we_cnt !== 1) begin n_mis++; $display("FAIL wr_we_cycles: got %0d want 1", we_cnt); end
   endtask

   task automatic test_contention();
      logic [3:0]  exp_ack;
      logic [15:0] exp_data;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) set_core(c, 1'b1, 1'b0, 16'(10 + c), 16'h0);
      for (int k = 0; k < 4; k++) begin
         tick(3);
         exp_ack  = 4'b0001 << k;
         exp_data = 16'hA000 + 16'(k);
         n_cmp++; if (bus.core_ack !== exp_ack) begin n_mis++; $display("FAIL cont_ack%0d: got %b want %b", k, bus.core_ack, exp_ack); end
         n_cmp++; if (bus.core_rdata !== exp_data) begin n_mis++; $display("FAIL cont_rdata%0d: got %h want %h", k, bus.core_rdata, exp_data); end
         set_core(k, 1'b0, 1'b0, 16'(10 + k), 16'h0);
         tick(1);
      end
      // Pointer wrapped to 0 after core 3: core 0 beats core 3.
      set_core(0, 1'b1, 1'b0, 16'd10, 16'h0);
      set_core(3, 1'b1, 1'b0, 16'd13, 16'h0);
      tick(3);
      n_cmp++; if (bus.core_ack !== 4'b0001) begin n_mis++; $display("FAIL cont_wrap_first: got %b want 0001", bus.core_ack); end
      set_core(0, 1'b0, 1'b0, 16'd10, 16'h0);
      tick(4);
      n_cmp++; if (bus.core_ack !== 4'b1000) begin n_mis++; $display("FAIL cont_wrap_second: got %b want 1000", bus.core_ack); end
      set_core(3, 1'b0, 1'b0, 16'd13, 16'h0);
      tick(1);
   endtask

   task automatic test_out_of_range();
      we_cnt = 0;
      set_core(0, 1'b1, 1'b1, 16'd1025, 16'h1234);
      tick(1);
      n_cmp++; if (bus.mem_we !== 1'b0) begin n_mis++; $display("FAIL oor_wr_we: got %b want 0", bus.mem_we); end
      tick(2);
      n_cmp++; if (bus.core_ack !== 4'b0001) begin n_mis++; $display("FAIL oor_wr_ack: got %b want 0001", bus.core_ack); end
      n_cmp++; if (bus.core_err !== 1'b1) begin n_mis++; $display("FAIL oor_wr_err: got %b want 1", bus.core_err); end
      set_core(0, 1'b1, 1'b0, 16'd1025, 16'h0);
      tick(4);
      n_cmp++; if (bus.core_ack !== 4'b0001) begin n_mis++; $display("FAIL oor_rd_ack: got %b want 0001", bus.core_ack); end
      n_cmp++; if (bus.core_err !== 1'b1) begin n_mis++; $display("FAIL oor_rd_err: got %b want 1", bus.core_err); end
      n_cmp++; if (bus.core_rdata !== 16'h0) begin n_mis++; $display("FAIL oor_rd_rdata: got %h want 0000", bus.core_rdata); end
      set_core(0, 1'b0, 1'b0, 16'd1025, 16'h0);
      tick(1);
      n_cmp++; if (bus.core_err !== 1'b0) begin n_mis++; $display("FAIL oor_err_pulse: got %b want 0", bus.core_err); end
      n_cmp++; if (we_cnt !== 0) begin n_mis++; $display("FAIL oor_no_we: got %0d want 0", we_cnt); end
      n_cmp++; if (ram[1025] !== 16'h0) begin n_mis++; $display("FAIL oor_ram: got %h want 0000", ram[1025]); end
      // Last valid word is writable.
      set_core(1, 1'b1, 1'b1, 16'd1024, 16'h5A5A);
      tick(3);
      n_cmp++; if (bus.core_err !== 1'b0) begin n_mis++; $display("FAIL edge_err: got %b want 0", bus.core_err); end
      set_core(1, 1'b0, 1'b0, 16'd1024, 16'h0);
      tick(1);
      n_cmp++; if (we_cnt !== 1) begin n_mis++; $display("FAIL edge_we: got %0d want 1", we_cnt); end
      n_cmp++; if (ram[1024] !== 16'h5A5A) begin n_mis++; $display("FAIL edge_ram: got %h want 5a5a", ram[1024]); end
   endtask

   task automatic test_reset_mid();
      set_core(2, 1'b1, 1'b0, 16'd5, 16'h0);
      tick(2);
      n_cmp++; if (bus.busy !== 1'b1) begin n_mis++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      n_cmp++; if (bus.core_ack !== 4'b0000) begin n_mis++; $display("FAIL mid_ack: got %b want 0000", bus.core_ack); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL mid_busy_rst: got %b want 0", bus.busy); end
      n_cmp++; if (bus.core_rdata !== 16'h0) begin n_mis++; $display("FAIL mid_rdata: got %h want 0000", bus.core_rdata); end
      n_cmp++; if (bus.mem_addr !== 16'h0) begin n_mis++; $display("FAIL mid_mem_addr: got %h want 0000", bus.mem_addr); end
      tick(2);
      n_cmp++; if (bus.core_ack !== 4'b0000) begin n_mis++; $display("FAIL mid_regrant_early: got %b want 0000", bus.core_ack); end
      tick(1);
      n_cmp++; if (bus.core_ack !== 4'b0100) begin n_mis++; $display("FAIL mid_regrant_ack: got %b want 0100", bus.core_ack); end
      n_cmp++; if (bus.core_rdata !== 16'd22) begin n_mis++; $display("FAIL mid_regrant_rdata: got %0d want 22", bus.core_rdata); end
      set_core(2, 1'b0, 1'b0, 16'd5, 16'h0);
      tick(1);
   endtask

   task automatic test_back_to_back();
      set_core(3, 1'b1, 1'b0, 16'd13, 16'h0);
      tick(3);
      n_cmp++; if (bus.core_ack !== 4'b1000) begin n_mis++; $display("FAIL b2b_ack1: got %b want 1000", bus.core_ack); end
      n_cmp++; if (bus.core_rdata !== 16'hA003) begin n_mis++; $display("FAIL b2b_rdata1: got %h want a003", bus.core_rdata); end
      set_core(3, 1'b1, 1'b0, 16'd5, 16'h0);
      tick(1);
      n_cmp++; if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL b2b_idle: got %b want 0", bus.busy); end
      tick(1);
      n_cmp++; if (bus.busy !== 1'b1) begin n_mis++; $display("FAIL b2b_restart: got %b want 1", bus.busy); end
      tick(2);
      n_cmp++; if (bus.core_ack !== 4'b1000) begin n_mis++; $display("FAIL b2b_ack2: got %b want 1000", bus.core_ack); end
      n_cmp++; if (bus.core_rdata !== 16'd22) begin n_mis++; $display("FAIL b2b_rdata2: got %0d want 22", bus.core_rdata); end
      set_core(3, 1'b0, 1'b0, 16'd5, 16'h0);
      tick(1);
   endtask

   initial begin
      n_cmp         = 0;
      n_mis         = 0;
      we_cnt        = 0;
      rst           = 1'b1;
      bus.core_req  = '0;
      bus.core_we   = '0;
      bus.core_addr = '0;
      bus.core_wdata= '0;
      for (int i = 0; i < 65536; i++) ram[i] = 16'h0;
      ram[5] = 16'd22;
      for (int i = 0; i < 4; i++) ram[10 + i] = 16'hA000 + 16'(i);

      test_reset();
      test_single_read();
      test_write_read();
      test_contention();
      test_out_of_range();
      test_reset_mid();
      test_back_to_back();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
